huffman_encode_ctrl: RTL
========================

HUFFMAN_ENCODE_CTRL -- requirements
Module: huffman_encode_ctrl

Interface
REQ-001 SHALL have parameter: OUT_W, default 32, packed output word width in bits, legal range 8..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: ctrl_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: sym_valid  input  1  ASCII symbol offered.
REQ-005 SHALL have port: sym_ready  output  1  symbol accepted when sym_valid && sym_ready.
REQ-006 SHALL have port: sym_data  input  7  ASCII symbol.
REQ-007 SHALL have port: sym_last  input  1  symbol ends the message; sampled with sym_data.
REQ-008 SHALL have port: tbl_rdAscii  output  7  read address to the code table.
REQ-009 SHALL have port: tbl_rdCode  input  128  code from table (combinational read), right-aligned.
REQ-010 SHALL have port: tbl_rdCodeLength  input  7  code length in bits; 0 = no code assigned.
REQ-011 SHALL have port: out_valid  output  1  packed word offered.
REQ-012 SHALL have port: out_ready  input  1  word consumed when out_valid && out_ready.
REQ-013 SHALL have port: out_data  output  OUT_W  packed bits, first-emitted bit in MSB.
REQ-014 SHALL have port: out_nbits  output  7  count of valid bits in out_data (0..OUT_W).
REQ-015 SHALL have port: out_last  output  1  final word of the message.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE; the table is not written while busy.
REQ-017 SHALL have port: err_nocode  output  1  sticky; set when a symbol with length 0 is looked up.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP, SHIFT, EMIT and FLUSH; sym_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on symbol handshake, SHALL register sym_data into sym_q and sym_last into last_q, then go to LOOKUP; tbl_rdAscii SHALL equal sym_q at all times.
REQ-020 LOOKUP (one cycle): SHALL capture tbl_rdCode into code_q and tbl_rdCodeLength into rem.
REQ-021 LOOKUP, length 0: SHALL set err_nocode and emit no bits; next state SHALL be FLUSH if last_q, else IDLE.
REQ-022 LOOKUP, length nonzero: next state SHALL be SHIFT.
REQ-023 SHIFT: each cycle SHALL write bit code_q[rem-1] into pack[OUT_W-1-fill], then increment fill and decrement rem, so codes are emitted MSB-first.
REQ-024 SHIFT: when fill reaches OUT_W, next state SHALL be EMIT with out_nbits=OUT_W.
REQ-025 SHIFT: otherwise, when rem reaches 0, next state SHALL be FLUSH if last_q, else IDLE; a partial pack SHALL be retained across symbols.
REQ-026 EMIT: out_valid=1; out_data, out_nbits and out_last SHALL be held stable until out_ready.
REQ-027 EMIT: out_last SHALL be 1 iff last_q && rem==0.
REQ-028 EMIT handshake: SHALL clear pack and fill; next state SHALL be SHIFT if rem>0, IDLE if rem==0 (including after a last word).
REQ-029 FLUSH: out_valid=1 with out_data=pack (unused low bits 0), out_nbits=fill, out_last=1; fill==0 SHALL produce a word with out_nbits=0.
REQ-030 FLUSH handshake: SHALL clear pack and fill, then go to IDLE.
REQ-031 Every message SHALL terminate with exactly one out_last word.
REQ-032 out_valid SHALL be 0 in IDLE, LOOKUP and SHIFT.
REQ-033 Per-symbol latency SHALL be 1 (accept) + 1 (LOOKUP) + L (SHIFT) cycles, plus EMIT/FLUSH backpressure cycles.
REQ-034 rem SHALL be 7 bits and fill SHALL be 7 bits; lengths up to 127 SHALL span multiple EMITs without loss.

Reset
REQ-035 ctrl_reset SHALL take priority over all other inputs in any state.
REQ-036 On ctrl_reset: state=IDLE; pack, fill, rem, code_q, sym_q, last_q=0; out_valid=0; out_last=0; out_nbits=0; out_data=0; err_nocode=0; busy=0; sym_ready=1 from the first cycle after reset deasserts.
REQ-037 ctrl_reset mid-message SHALL discard all buffered bits with no flush word.

Verification
REQ-038 OUT_W=8; 'A'->code 3'b101 L=3, last=1; out_ready=1 -> one FLUSH word: out_data=8'hA0, out_nbits=3, out_last=1; symbol accepted to out_valid = 5 cycles.
REQ-039 OUT_W=8; 'B'->6'b110011 sent 2x, second last -> word 8'hCF nbits=8 last=0, then 8'h30 nbits=4 last=1.
REQ-040 OUT_W=8; single symbol L=8 code 8'h5A, last -> one EMIT 8'h5A nbits=8 last=1; no extra FLUSH word.
REQ-041 Symbol with length 0, last=1, empty pack -> err_nocode=1 sticky; word nbits=0 last=1.
REQ-042 out_ready held 0 for 10 cycles during EMIT -> out_data stable, sym_ready=0, no bits lost; release -> resumes in SHIFT.
REQ-043 Assert ctrl_reset while in SHIFT with fill=5 -> next cycle IDLE, out_valid=0, err_nocode=0; the next message's first word has no stale bits.

Source files
------------

// File: rtl/huffman_encode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : huffman_encode_ctrl
// Brief    : Looks up ASCII symbols in a Huffman code table and packs the
//            codes MSB-first into OUT_W-bit words with valid/ready framing.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_encode_ctrl #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             ctrl_reset,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [6:0]       sym_data,
  input  logic             sym_last,
  output logic [6:0]       tbl_rdAscii,
  input  logic [127:0]     tbl_rdCode,
  input  logic [6:0]       tbl_rdCodeLength,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [6:0]       out_nbits,
  output logic             out_last,
  output logic             busy,
  output logic             err_nocode
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_SHIFT  = 3'd2,
    S_EMIT   = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam logic [6:0] C_FULL = 7'(OUT_W);
  localparam logic [6:0] C_TOP  = 7'(OUT_W - 1);

  state_t             r_state;
  logic [6:0]         r_sym_q;
  logic               r_last_q;
  logic [127:0]       r_code_q;
  logic [6:0]         r_rem;
  logic [6:0]         r_fill;
  logic [OUT_W-1:0]   r_pack;
  logic               r_err;
  logic               r_out_last;

  logic [6:0]         w_rem_nxt;
  logic [6:0]         w_fill_nxt;
  logic [6:0]         w_pos;
  logic               w_bit;
  logic [OUT_W-1:0]   w_bit_mask;

  // Next code bit is code_q[rem-1]; it lands at pack[OUT_W-1-fill].
  assign w_rem_nxt  = r_rem - 7'd1;
  assign w_fill_nxt = r_fill + 7'd1;
  assign w_bit      = r_code_q[w_rem_nxt];
  assign w_pos      = C_TOP - r_fill;
  assign w_bit_mask = {{(OUT_W-1){1'b0}}, w_bit} << w_pos;

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      r_state    <= S_IDLE;
      r_sym_q    <= '0;
      r_last_q   <= 1'b0;
      r_code_q   <= '0;
      r_rem      <= '0;
      r_fill     <= '0;
      r_pack     <= '0;
      r_err      <= 1'b0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sym_valid) begin
            r_sym_q  <= sym_data;
            r_last_q <= sym_last;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_code_q <= tbl_rdCode;
          r_rem    <= tbl_rdCodeLength;
          if (tbl_rdCodeLength == 7'd0) begin
            r_err <= 1'b1;
            if (r_last_q) begin
              r_state    <= S_FLUSH;
              r_out_last <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_pack <= r_pack | w_bit_mask;
          r_fill <= w_fill_nxt;
          r_rem  <= w_rem_nxt;
          // A full word takes precedence; a last symbol ending exactly on a
          // word boundary is tagged here so no empty flush word follows.
          if (w_fill_nxt == C_FULL) begin
            r_state    <= S_EMIT;
            r_out_last <= r_last_q && (w_rem_nxt == 7'd0);
          end else if (w_rem_nxt == 7'd0) begin
            if (r_last_q) begin
              r_state    <= S_FLUSH;
              r_out_last <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_pack     <= '0;
            r_fill     <= '0;
            r_out_last <= 1'b0;
            r_state    <= (r_rem != 7'd0) ? S_SHIFT : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            r_pack     <= '0;
            r_fill     <= '0;
            r_out_last <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sym_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign tbl_rdAscii = r_sym_q;
  assign out_valid   = (r_state == S_EMIT) || (r_state == S_FLUSH);
  assign out_data    = out_valid ? r_pack : '0;
  assign out_nbits   = out_valid ? r_fill : 7'd0;
  assign out_last    = r_out_last;
  assign err_nocode  = r_err;

endmodule
`default_nettype wire
